// File: rtl/ntt_pkg.sv
// Shared constants and types for the NTT datapath: field modulus, Montgomery
// constants and the multiplier latency the butterfly aligns to.
package ntt_pkg;

    localparam int unsigned DATA_WIDTH   = 12;
    localparam logic [DATA_WIDTH-1:0] Q  = DATA_WIDTH'(3329);

    localparam bit          MULTYPE_KRED = 1'b0;
    localparam int unsigned MWR2MM_D     = 4;
    localparam int unsigned KRED_L       = 2;
    localparam int unsigned MO_MUL_LAT   = MULTYPE_KRED ? KRED_L + 2
                                         : (DATA_WIDTH + MWR2MM_D - 1) / MWR2MM_D + 2;

    typedef enum logic {BF_CT, BF_GS} bf_mode_e;

    // -Q^-1 mod 2^DATA_WIDTH via Newton iteration (precision doubles per step, Q odd)
    function automatic logic [DATA_WIDTH-1:0] mont_qneg_inv();
        logic [DATA_WIDTH-1:0] x;
        x = DATA_WIDTH'(1);
        for (int unsigned i = 0; i < 6; i++) begin
            x = x * (DATA_WIDTH'(2) - Q * x);
        end
        return DATA_WIDTH'(0) - x;
    endfunction

    localparam logic [DATA_WIDTH-1:0] Q_NEG_INV = mont_qneg_inv();

endpackage

// File: rtl/mo_mul.sv
// Montgomery multiplier: p = a*b*2^-WIDTH mod Q, result in [0,Q], delivered
// MO_MUL_LAT cycles after the operands are presented.
module mo_mul
    import ntt_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_WIDTH
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] p
);

    logic [2*WIDTH-1:0] t;
    logic [WIDTH-1:0]   m;
    logic [2*WIDTH:0]   u_full;
    logic [WIDTH:0]     u;
    logic [WIDTH:0]     q_ext;
    logic [WIDTH-1:0]   p_comb;
    logic [WIDTH-1:0]   pipe [MO_MUL_LAT];

    assign q_ext  = (WIDTH+1)'(Q);
    assign t      = (2*WIDTH)'(a) * (2*WIDTH)'(b);
    assign m      = t[WIDTH-1:0] * WIDTH'(Q_NEG_INV);
    assign u_full = (2*WIDTH+1)'(t) + (2*WIDTH+1)'(m) * (2*WIDTH+1)'(Q);
    assign u      = (WIDTH+1)'(u_full >> WIDTH);
    // u < 2Q; only strictly-greater values are folded, so Q itself may emerge
    assign p_comb = (u > q_ext) ? WIDTH'(u - q_ext) : WIDTH'(u);

    always_ff @(posedge clk) begin
        pipe[0] <= p_comb;
        for (int unsigned i = 1; i < MO_MUL_LAT; i++) begin
            pipe[i] <= pipe[i-1];
        end
    end

    assign p = pipe[MO_MUL_LAT-1];

endmodule

// File: rtl/mod_addsub.sv
// Combinational modular add/sub pair. Inputs a in [0,Q), x in [0,Q]; the
// value Q on x behaves as 0. Both results land in [0,Q).
module mod_addsub
    import ntt_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] x,
    output logic [DATA_WIDTH-1:0] sum,
    output logic [DATA_WIDTH-1:0] diff
);

    logic [DATA_WIDTH:0] s;
    logic [DATA_WIDTH:0] d;
    logic [DATA_WIDTH:0] q_ext;

    assign q_ext = {1'b0, Q};
    assign s     = {1'b0, a} + {1'b0, x};
    assign d     = {1'b0, a} - {1'b0, x};

    assign sum  = (s >= q_ext) ? DATA_WIDTH'(s - q_ext) : DATA_WIDTH'(s);
    assign diff = d[DATA_WIDTH] ? DATA_WIDTH'(d + q_ext) : DATA_WIDTH'(d);

endmodule

// File: rtl/ntt_butterfly.sv
// Radix-2 CT/GS butterfly around a single mo_mul; fixed MO_MUL_LAT+3 latency
// in both modes, one-cycle bubble when a CT op directly follows a GS op.
module ntt_butterfly
    import ntt_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  mode,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [DATA_WIDTH-1:0] w,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out0,
    output logic [DATA_WIDTH-1:0] out1
);

    localparam int unsigned L = MO_MUL_LAT;

    // Index k of each chain holds the op that is k+1 cycles past acceptance
    logic                  vld  [L+2];
    bf_mode_e              md   [L+2];
    logic [DATA_WIDTH-1:0] pass [L+2];

    logic [DATA_WIDTH-1:0] b0, w0, w1, diff1;
    logic [DATA_WIDTH-1:0] gs_sum, gs_diff, ct_sum, ct_diff, ct_sum_r, ct_diff_r;
    logic [DATA_WIDTH-1:0] mul_x, mul_w, prod;
    logic                  fire, gs_last, mul_ct;

    assign gs_last  = vld[0] && (md[0] == BF_GS);
    assign in_ready = !(gs_last && in_valid && (bf_mode_e'(mode) == BF_CT));
    assign fire     = in_valid && in_ready;

    // CT occupies the multiplier at age 1, GS at age 2
    assign mul_ct = vld[0] && (md[0] == BF_CT);
    assign mul_x  = mul_ct ? b0 : diff1;
    assign mul_w  = mul_ct ? w0 : w1;

    mod_addsub u_gs_addsub (
        .a    (pass[0]),
        .x    (b0),
        .sum  (gs_sum),
        .diff (gs_diff)
    );

    mo_mul #(.WIDTH(DATA_WIDTH)) u_mo_mul (
        .clk (clk),
        .a   (mul_w),
        .b   (mul_x),
        .p   (prod)
    );

    mod_addsub u_ct_addsub (
        .a    (pass[L]),
        .x    (prod),
        .sum  (ct_sum),
        .diff (ct_diff)
    );

    always_ff @(posedge clk) begin
        pass[0]   <= a;
        b0        <= b;
        w0        <= w;
        w1        <= w0;
        diff1     <= gs_diff;
        pass[1]   <= (md[0] == BF_GS) ? gs_sum : pass[0];
        for (int unsigned i = 2; i < L + 2; i++) begin
            pass[i] <= pass[i-1];
        end
        ct_sum_r  <= ct_sum;
        ct_diff_r <= ct_diff;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < L + 2; i++) begin
                vld[i] <= 1'b0;
                md[i]  <= BF_CT;
            end
            out_valid <= 1'b0;
            out0      <= '0;
            out1      <= '0;
        end else begin
            vld[0] <= fire;
            md[0]  <= bf_mode_e'(mode);
            for (int unsigned i = 1; i < L + 2; i++) begin
                vld[i] <= vld[i-1];
                md[i]  <= md[i-1];
            end
            out_valid <= vld[L+1];
            if (vld[L+1]) begin
                if (md[L+1] == BF_CT) begin
                    out0 <= ct_sum_r;
                    out1 <= ct_diff_r;
                end else begin
                    out0 <= pass[L+1];
                    out1 <= (prod == Q) ? '0 : prod;
                end
            end
        end
    end

endmodule
